soc_mem_reader: RTL and testbench

Avalon-MM read master that drains a block of 32-bit words from the 32-bit port of the SoC dual-port on-chip memory and presents them as a valid/ready stream with an end-of-block marker. It sits between the memory's second slave port and downstream receiver post-processing. Reads are pipelined against the memory's fixed one-cycle read latency. A small skid FIFO absorbs downstream backpressure without losing in-flight data.

---
 rtl/soc_mem_reader_pkg.sv | 16 +
 rtl/soc_mem_reader_fifo.sv | 45 ++++
 rtl/soc_mem_reader.sv | 142 ++++++++++++++
 tb/tb_soc_mem_reader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_reader_pkg.sv
// Shared state encoding and default widths for the soc_mem_reader block.
package soc_mem_reader_pkg;

  localparam int unsigned DEF_ADDR_W     = 10;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_LEN_W      = 11;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/soc_mem_reader_fifo.sv
// Skid FIFO holding {last, data} entries read back from memory; head is show-ahead.
module soc_mem_reader_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_entry,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the stream data output reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/soc_mem_reader.sv
// Avalon-MM read master draining a memory block into a valid/ready stream.
// Optional running checksum of accepted words with SOC_MEM_READER_CKSUM_EN.
module soc_mem_reader
  import soc_mem_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LEN_W      = DEF_LEN_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
`ifdef SOC_MEM_READER_CKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PEND_W = CNT_W + 1;

  state_t              state;
  state_t              state_n;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    remaining;
  logic                cs_last;
  logic                inflight;
  logic                inflight_last;
  logic                issue_c;
  logic                load_c;
  logic [PEND_W-1:0]   pending_c;
  logic [CNT_W-1:0]    fifo_count;
  logic [DATA_W:0]     fifo_head;

  assign m_write      = 1'b0;
  assign m_byteenable = 4'hF;

  // Next state and read-issue decision; pending covers every read not yet in the FIFO.
  always_comb begin
    state_n   = state;
    issue_c   = 1'b0;
    load_c    = 1'b0;
    pending_c = PEND_W'(fifo_count) + PEND_W'(inflight) + PEND_W'(m_chipselect);
    case (state)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_n = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        if ((remaining != '0) && (pending_c < PEND_W'(FIFO_DEPTH))) issue_c = 1'b1;
        if (issue_c && (remaining == LEN_W'(1))) state_n = DRAIN;
      end
      DRAIN: begin
        if (st_valid && st_ready && st_last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Read pipeline: decision -> chipselect cycle -> data cycle -> FIFO push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      m_clken       <= 1'b0;
      m_chipselect  <= 1'b0;
      m_address     <= '0;
      cs_last       <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      addr          <= '0;
      remaining     <= '0;
    end else begin
      state         <= state_n;
      busy          <= (state_n != IDLE);
      done          <= (state_n == DONE);
      m_clken       <= 1'b1;
      m_chipselect  <= issue_c;
      cs_last       <= issue_c && (remaining == LEN_W'(1));
      inflight      <= m_chipselect;
      inflight_last <= cs_last;
      if (load_c) begin
        addr      <= base_addr;
        remaining <= length;
      end else if (issue_c) begin
        m_address <= addr;
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  soc_mem_reader_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .push       (inflight),
    .push_entry ({inflight_last, m_readdata}),
    .pop        (st_ready),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  assign st_valid = (fifo_count != '0);
  assign st_data  = fifo_head[DATA_W-1:0];
  assign st_last  = fifo_head[DATA_W];

`ifdef SOC_MEM_READER_CKSUM_EN
  // Wrap-around sum of accepted words; holds after done until the next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (load_c) begin
      checksum <= '0;
    end else if (st_valid && st_ready) begin
      checksum <= checksum + 32'(st_data);
    end
  end
`endif

endmodule

// File: tb/tb_soc_mem_reader.sv
// Directed bench for soc_mem_reader with a one-cycle-latency memory model.
module tb_soc_mem_reader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        busy;
  logic        done;
  logic [9:0]  m_address;
  logic        m_chipselect;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic        m_clken;
  logic [31:0] m_readdata;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic        st_last;
`ifdef SOC_MEM_READER_CKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  soc_mem_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_last      (st_last)
`ifdef SOC_MEM_READER_CKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (m_chipselect) m_readdata <= mem[m_address];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a block and follows it cycle by cycle until done (bounded).
  task automatic run_block(input string tag, input logic [9:0] base, input int n,
                           input int ready_mode, input int exp_done, input int exp_first);
    int          got;
    int          issued;
    int          done_at;
    int          done_cnt;
    int          first_valid;
    int          max_fifo;
    int          stall_bad;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [9:0]  a;
    got = 0; issued = 0; done_at = -1; done_cnt = 0; first_valid = -1;
    max_fifo = 0; stall_bad = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    start = 1'b1; base_addr = base; length = 11'(n);
    for (int c = 0; c < n * 4 + 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 2 && n > 4) begin
        start = 1'b1; base_addr = 10'h200; length = 11'd5;
      end
      if (int'(dut.fifo_count) > max_fifo) max_fifo = int'(dut.fifo_count);
      if (prev_stall && (st_data !== prev_data || st_last !== prev_last)) stall_bad++;
      if (st_valid && first_valid < 0) first_valid = c;
      if (m_chipselect) begin
        a = base + 10'(issued);
        check({tag, "_addr"}, 64'(m_address), 64'(a));
        issued++;
      end
      st_ready = (ready_mode == 0) ? 1'b1 : (c % 3 == 0);
      if (st_valid && st_ready) begin
        a = base + 10'(got);
        check({tag, "_data"}, 64'(st_data), 64'(mem[a]));
        check({tag, "_last"}, 64'(st_last), 64'(got == n - 1));
        got++;
      end
      prev_stall = st_valid && !st_ready;
      prev_data  = st_data;
      prev_last  = st_last;
      if (done_at >= 0 && c == done_at + 1) check({tag, "_busy_after"}, 64'(busy), 64'd0);
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        end
      end
      if (done_at >= 0 && c >= done_at + 2) break;
    end
    start = 1'b0;
    check({tag, "_words"}, 64'(got), 64'(n));
    check({tag, "_issues"}, 64'(issued), 64'(n));
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_stall_stable"}, 64'(stall_bad), 64'd0);
    check({tag, "_fifo_bound"}, 64'(max_fifo <= 4), 64'd1);
    if (exp_done >= 0) check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
    if (exp_first >= 0) check({tag, "_first_valid"}, 64'(first_valid), 64'(exp_first));
  endtask

  initial begin
    int busy_seen;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; st_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + 32'(i);

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cs", 64'(m_chipselect), 64'd0);
    check("rst_addr", 64'(m_address), 64'd0);
    check("rst_valid", 64'(st_valid), 64'd0);
    check("rst_last", 64'(st_last), 64'd0);
    check("rst_data", 64'(st_data), 64'd0);
    check("rst_clken", 64'(m_clken), 64'd0);
    check("write_low", 64'(m_write), 64'd0);
    check("byteenable", 64'(m_byteenable), 64'hF);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("clken_on", 64'(m_clken), 64'd1);

    run_block("blk8", 10'h010, 8, 0, 11, 3);
    run_block("wrap", 10'h3FE, 4, 0, 7, 3);
    run_block("zero", 10'h020, 0, 0, 0, -1);
    run_block("stall", 10'h040, 16, 1, -1, 3);

    // Asynchronous reset in the middle of a long block.
    st_ready = 1'b1; start = 1'b1; base_addr = 10'h000; length = 11'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3; reset_n = 1'b0; #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_cs", 64'(m_chipselect), 64'd0);
    check("mid_rst_addr", 64'(m_address), 64'd0);
    check("mid_rst_valid", 64'(st_valid), 64'd0);
    check("mid_rst_data", 64'(st_data), 64'd0);
    check("mid_rst_clken", 64'(m_clken), 64'd0);
    busy_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy || done || st_valid) busy_seen++;
    end
    check("mid_rst_hold", 64'(busy_seen), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 64'({busy, done, st_valid, m_chipselect}), 64'd0);
    run_block("post_rst", 10'h100, 2, 0, 5, 3);

`ifdef SOC_MEM_READER_CKSUM_EN
    mem[10'h050] = 32'hFFFF_FFFF;
    mem[10'h051] = 32'h0000_0002;
    run_block("cksum", 10'h050, 2, 0, 5, 3);
    check("cksum_value", 64'(checksum), 64'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
